// File: rtl/nibble_serial_adder_pkg.sv
// Shared encodings for the nibble-serial add/subtract engine and its slice.
package nibble_serial_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/nibble_adder_slice.sv
// 4-bit ripple-carry adder; the carry into bit 3 is exposed for overflow detection.
module nibble_adder_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               c3
);

    logic [SLICE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
        end
    end

    assign cout = c[SLICE_W];
    assign c3   = c[SLICE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract done one nibble per cycle, LSB first; result valid NIB+1 edges after accept.
// Operands taken only in IDLE; the result holds in DONE until out_ready, no same-cycle re-accept.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl
);

    localparam int CW = $clog2(NIB) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             carry_reg;
    logic [CW-1:0]    nib_cnt;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic               slice_c3;
    logic [WIDTH-1:0]   s_next;

    nibble_adder_slice u_slice (
        .a    (a_reg[SLICE_W-1:0]),
        .b    (b_reg[SLICE_W-1:0]),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    // New nibble enters at the top so the LSB nibble ends up at the bottom after NIB passes.
    assign s_next = (s_reg >> SLICE_W) | (WIDTH'(slice_s) << (WIDTH - SLICE_W));
    assign sum    = s_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            nib_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cout      <= 1'b0;
            ovfl      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        nib_cnt   <= '0;
                        in_ready  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> SLICE_W;
                    b_reg     <= b_reg >> SLICE_W;
                    s_reg     <= s_next;
                    carry_reg <= slice_cout;
                    if (nib_cnt == CW'(NIB - 1)) begin
                        cout  <= slice_cout;
                        ovfl  <= slice_c3 ^ slice_cout;
                        state <= DONE;
                    end else begin
                        nib_cnt <= nib_cnt + CW'(1);
                    end
                end
                DONE: begin
                    // out_valid rises one cycle into DONE; only a presented result can be taken.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
